// File: rtl/rf_scoreboard.sv
// Per-thread architectural register file with a pending scoreboard and exception special registers (rm0..rm2).
// Combinational read ports with same-cycle writeback bypass; all updates on the rising clock edge.
module rf_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int ROB_ID_W    = 3,
   parameter int THREADS     = 4,
   parameter int THR_W       = 2,
   parameter int PC_W        = 32,
   parameter int XCPT_TYPE_W = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [THREADS-1:0]     flush_pipeline,
   input  logic                   alloc_valid,
   input  logic [THR_W-1:0]       alloc_thread_id,
   input  logic [ADDR_W-1:0]      alloc_dest,
   input  logic [ROB_ID_W-1:0]    alloc_rob_id,
   input  logic                   wb_writeEn,
   input  logic [DATA_W-1:0]      wb_data,
   input  logic [ADDR_W-1:0]      wb_dest,
   input  logic [ROB_ID_W-1:0]    wb_instr_id,
   input  logic [THR_W-1:0]       wb_thread_id,
   input  logic                   xcpt_valid,
   input  logic [XCPT_TYPE_W-1:0] xcpt_type,
   input  logic [PC_W-1:0]        xcpt_pc,
   input  logic [DATA_W-1:0]      xcpt_addr,
   input  logic [THR_W-1:0]       xcpt_thread_id,
   input  logic [THR_W-1:0]       rd_thread_id,
   input  logic [ADDR_W-1:0]      src1_addr,
   input  logic [ADDR_W-1:0]      src2_addr,
   output logic [DATA_W-1:0]      src1_data,
   output logic [DATA_W-1:0]      src2_data,
   output logic                   src1_pending,
   output logic                   src2_pending,
   output logic [ROB_ID_W-1:0]    src1_rob_id,
   output logic [ROB_ID_W-1:0]    src2_rob_id,
   output logic [PC_W-1:0]        rm0_pc,
   output logic [DATA_W-1:0]      rm1_addr,
   output logic [DATA_W-1:0]      rm2_type
);

   logic [DATA_W-1:0]      data_q [THREADS][NUM_REGS];
   logic [DATA_W-1:0]      data_d [THREADS][NUM_REGS];
   logic [NUM_REGS-1:0]    pend_q [THREADS];
   logic [NUM_REGS-1:0]    pend_d [THREADS];
   logic [ROB_ID_W-1:0]    pend_id_q [THREADS][NUM_REGS];
   logic [ROB_ID_W-1:0]    pend_id_d [THREADS][NUM_REGS];
   logic [PC_W-1:0]        rm0_q [THREADS];
   logic [PC_W-1:0]        rm0_d [THREADS];
   logic [DATA_W-1:0]      rm1_q [THREADS];
   logic [DATA_W-1:0]      rm1_d [THREADS];
   logic [XCPT_TYPE_W-1:0] rm2_q [THREADS];
   logic [XCPT_TYPE_W-1:0] rm2_d [THREADS];

   logic wb_clears;

   // Order matters: writeback clear, then flush, then allocation, so allocation wins over the clear.
   always_comb begin
      data_d    = data_q;
      pend_d    = pend_q;
      pend_id_d = pend_id_q;
      rm0_d     = rm0_q;
      rm1_d     = rm1_q;
      rm2_d     = rm2_q;
      wb_clears = 1'b0;

      if (wb_writeEn && (wb_dest != '0)) begin
         data_d[wb_thread_id][wb_dest] = wb_data;
         wb_clears = pend_q[wb_thread_id][wb_dest] &&
                     (pend_id_q[wb_thread_id][wb_dest] == wb_instr_id);
         if (wb_clears) begin
            pend_d[wb_thread_id][wb_dest] = 1'b0;
         end
      end

      for (int t = 0; t < THREADS; t++) begin
         if (flush_pipeline[t]) begin
            pend_d[t] = '0;
         end
      end

      if (alloc_valid && (alloc_dest != '0) && !flush_pipeline[alloc_thread_id]) begin
         pend_d[alloc_thread_id][alloc_dest]    = 1'b1;
         pend_id_d[alloc_thread_id][alloc_dest] = alloc_rob_id;
      end

      if (xcpt_valid) begin
         rm0_d[xcpt_thread_id] = xcpt_pc;
         rm1_d[xcpt_thread_id] = xcpt_addr;
         rm2_d[xcpt_thread_id] = xcpt_type;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int t = 0; t < THREADS; t++) begin
            pend_q[t] <= '0;
            rm0_q[t]  <= '0;
            rm1_q[t]  <= '0;
            rm2_q[t]  <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
               data_q[t][r]    <= '0;
               pend_id_q[t][r] <= '0;
            end
         end
      end else begin
         data_q    <= data_d;
         pend_q    <= pend_d;
         pend_id_q <= pend_id_d;
         rm0_q     <= rm0_d;
         rm1_q     <= rm1_d;
         rm2_q     <= rm2_d;
      end
   end

   // Read port 1: the bypass shows the committing value and the post-clear pending state.
   always_comb begin
      src1_data    = '0;
      src1_pending = 1'b0;
      src1_rob_id  = '0;
      if (src1_addr != '0) begin
         src1_data    = data_q[rd_thread_id][src1_addr];
         src1_pending = pend_q[rd_thread_id][src1_addr];
         src1_rob_id  = pend_id_q[rd_thread_id][src1_addr];
         if (wb_writeEn && (wb_thread_id == rd_thread_id) && (wb_dest == src1_addr)) begin
            src1_data = wb_data;
            if (src1_pending && (src1_rob_id == wb_instr_id)) begin
               src1_pending = 1'b0;
            end
         end
      end
   end

   always_comb begin
      src2_data    = '0;
      src2_pending = 1'b0;
      src2_rob_id  = '0;
      if (src2_addr != '0) begin
         src2_data    = data_q[rd_thread_id][src2_addr];
         src2_pending = pend_q[rd_thread_id][src2_addr];
         src2_rob_id  = pend_id_q[rd_thread_id][src2_addr];
         if (wb_writeEn && (wb_thread_id == rd_thread_id) && (wb_dest == src2_addr)) begin
            src2_data = wb_data;
            if (src2_pending && (src2_rob_id == wb_instr_id)) begin
               src2_pending = 1'b0;
            end
         end
      end
   end

   assign rm0_pc   = rm0_q[rd_thread_id];
   assign rm1_addr = rm1_q[rd_thread_id];
   assign rm2_type = {{(DATA_W-XCPT_TYPE_W){1'b0}}, rm2_q[rd_thread_id]};

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: directed scenarios plus randomized traffic against an array-based reference model.
module tb_rf_scoreboard;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  flush_pipeline;
   logic        alloc_valid;
   logic [1:0]  alloc_thread_id;
   logic [4:0]  alloc_dest;
   logic [2:0]  alloc_rob_id;
   logic        wb_writeEn;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic [2:0]  wb_instr_id;
   logic [1:0]  wb_thread_id;
   logic        xcpt_valid;
   logic [1:0]  xcpt_type;
   logic [31:0] xcpt_pc;
   logic [31:0] xcpt_addr;
   logic [1:0]  xcpt_thread_id;
   logic [1:0]  rd_thread_id;
   logic [4:0]  src1_addr, src2_addr;
   logic [31:0] src1_data, src2_data;
   logic        src1_pending, src2_pending;
   logic [2:0]  src1_rob_id, src2_rob_id;
   logic [31:0] rm0_pc, rm1_addr, rm2_type;

   rf_scoreboard dut (
      .clock(clock), .reset(reset), .flush_pipeline(flush_pipeline),
      .alloc_valid(alloc_valid), .alloc_thread_id(alloc_thread_id),
      .alloc_dest(alloc_dest), .alloc_rob_id(alloc_rob_id),
      .wb_writeEn(wb_writeEn), .wb_data(wb_data), .wb_dest(wb_dest),
      .wb_instr_id(wb_instr_id), .wb_thread_id(wb_thread_id),
      .xcpt_valid(xcpt_valid), .xcpt_type(xcpt_type), .xcpt_pc(xcpt_pc),
      .xcpt_addr(xcpt_addr), .xcpt_thread_id(xcpt_thread_id),
      .rd_thread_id(rd_thread_id), .src1_addr(src1_addr), .src2_addr(src2_addr),
      .src1_data(src1_data), .src2_data(src2_data),
      .src1_pending(src1_pending), .src2_pending(src2_pending),
      .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
      .rm0_pc(rm0_pc), .rm1_addr(rm1_addr), .rm2_type(rm2_type)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: architectural view per thread.
   logic [31:0] m_data [4][32];
   bit          m_pend [4][32];
   logic [2:0]  m_id   [4][32];
   logic [31:0] m_rm0 [4];
   logic [31:0] m_rm1 [4];
   logic [31:0] m_rm2 [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic idle();
      flush_pipeline = '0; alloc_valid = 0; alloc_thread_id = '0; alloc_dest = '0;
      alloc_rob_id = '0; wb_writeEn = 0; wb_data = '0; wb_dest = '0; wb_instr_id = '0;
      wb_thread_id = '0; xcpt_valid = 0; xcpt_type = '0; xcpt_pc = '0; xcpt_addr = '0;
      xcpt_thread_id = '0;
   endtask

   task automatic model_reset();
      for (int t = 0; t < 4; t++) begin
         m_rm0[t] = '0; m_rm1[t] = '0; m_rm2[t] = '0;
         for (int r = 0; r < 32; r++) begin
            m_data[t][r] = '0; m_pend[t][r] = 0; m_id[t][r] = '0;
         end
      end
   endtask

   // What a reader should see this cycle: stored state, overridden by a same-cycle commit.
   task automatic expect_read(input logic [4:0] a, output logic [31:0] d, output bit p,
                              output logic [2:0] id);
      d = '0; p = 0; id = '0;
      if (a != 0) begin
         d = m_data[rd_thread_id][a]; p = m_pend[rd_thread_id][a]; id = m_id[rd_thread_id][a];
         if (wb_writeEn && wb_thread_id == rd_thread_id && wb_dest == a) begin
            d = wb_data;
            if (p && id == wb_instr_id) p = 0;
         end
      end
   endtask

   task automatic check_all();
      logic [31:0] d; bit p; logic [2:0] id;
      expect_read(src1_addr, d, p, id);
      check("src1_data", src1_data, d);
      check("src1_pending", {31'b0, src1_pending}, {31'b0, p});
      if (p) check("src1_rob_id", {29'b0, src1_rob_id}, {29'b0, id});
      expect_read(src2_addr, d, p, id);
      check("src2_data", src2_data, d);
      check("src2_pending", {31'b0, src2_pending}, {31'b0, p});
      if (p) check("src2_rob_id", {29'b0, src2_rob_id}, {29'b0, id});
      check("rm0_pc", rm0_pc, m_rm0[rd_thread_id]);
      check("rm1_addr", rm1_addr, m_rm1[rd_thread_id]);
      check("rm2_type", rm2_type, m_rm2[rd_thread_id]);
   endtask

   task automatic model_commit();
      if (wb_writeEn && wb_dest != 0) begin
         m_data[wb_thread_id][wb_dest] = wb_data;
         if (m_pend[wb_thread_id][wb_dest] && m_id[wb_thread_id][wb_dest] == wb_instr_id)
            m_pend[wb_thread_id][wb_dest] = 0;
      end
      for (int t = 0; t < 4; t++)
         if (flush_pipeline[t])
            for (int r = 0; r < 32; r++) m_pend[t][r] = 0;
      if (alloc_valid && alloc_dest != 0 && !flush_pipeline[alloc_thread_id]) begin
         m_pend[alloc_thread_id][alloc_dest] = 1;
         m_id[alloc_thread_id][alloc_dest]   = alloc_rob_id;
      end
      if (xcpt_valid) begin
         m_rm0[xcpt_thread_id] = xcpt_pc;
         m_rm1[xcpt_thread_id] = xcpt_addr;
         m_rm2[xcpt_thread_id] = {30'b0, xcpt_type};
      end
   endtask

   // Called at a negedge with inputs already driven; returns at the next negedge.
   task automatic step();
      #1 check_all();
      @(posedge clock);
      model_commit();
      @(negedge clock);
   endtask

   task automatic rd(input logic [1:0] t, input logic [4:0] a1, input logic [4:0] a2);
      rd_thread_id = t; src1_addr = a1; src2_addr = a2;
   endtask

   task automatic alloc(input logic [1:0] t, input logic [4:0] r, input logic [2:0] id);
      alloc_valid = 1; alloc_thread_id = t; alloc_dest = r; alloc_rob_id = id;
   endtask

   task automatic wb(input logic [1:0] t, input logic [4:0] r, input logic [2:0] id,
                     input logic [31:0] d);
      wb_writeEn = 1; wb_thread_id = t; wb_dest = r; wb_instr_id = id; wb_data = d;
   endtask

   initial begin
      idle();
      rd(0, 5, 0);
      model_reset();
      #22;
      check("reset_src1_data", src1_data, 32'h0);
      check("reset_src1_pending", {31'b0, src1_pending}, 32'h0);
      check("reset_rm0", rm0_pc, 32'h0);
      @(negedge clock);
      reset = 1;
      @(negedge clock);
      step();

      // Allocate, then commit with matching id; bypass visible same cycle.
      alloc(1, 3, 2); step(); idle();
      rd(1, 3, 3); #1;
      check("alloc_pending", {31'b0, src1_pending}, 32'h1);
      check("alloc_rob_id", {29'b0, src1_rob_id}, 32'h2);
      wb(1, 3, 2, 32'hDEADBEEF); #1;
      check("bypass_data", src1_data, 32'hDEADBEEF);
      check("bypass_pending", {31'b0, src1_pending}, 32'h0);
      step(); idle(); #1;
      check("commit_persist", src1_data, 32'hDEADBEEF);
      check("commit_pend_clear", {31'b0, src2_pending}, 32'h0);
      step();

      // Younger producer keeps the register pending across an older commit.
      alloc(0, 7, 1); step(); idle();
      alloc(0, 7, 4); step(); idle();
      wb(0, 7, 1, 32'h11); step(); idle();
      rd(0, 7, 0); #1;
      check("stale_wb_data", src1_data, 32'h11);
      check("stale_wb_pending", {31'b0, src1_pending}, 32'h1);
      check("stale_wb_id", {29'b0, src1_rob_id}, 32'h4);
      wb(0, 7, 4, 32'h22); step(); idle(); #1;
      check("young_wb_data", src1_data, 32'h22);
      check("young_wb_pending", {31'b0, src1_pending}, 32'h0);
      step();

      // Same-cycle alloc and wb to the same register: allocation wins.
      alloc(2, 9, 5); wb(2, 9, 3, 32'h55); step(); idle();
      rd(2, 9, 9); #1;
      check("alloc_wb_data", src1_data, 32'h55);
      check("alloc_wb_pending", {31'b0, src1_pending}, 32'h1);
      check("alloc_wb_id", {29'b0, src2_rob_id}, 32'h5);
      step();

      // Flush thread 0 only, with a dropped same-cycle allocation.
      alloc(0, 1, 1); step(); idle();
      alloc(0, 2, 2); step(); idle();
      alloc(3, 1, 3); step(); idle();
      alloc(3, 2, 4); step(); idle();
      flush_pipeline = 4'b0001; alloc(0, 4, 6); step(); idle();
      rd(0, 1, 2); #1;
      check("flush_t0_r1", {31'b0, src1_pending}, 32'h0);
      check("flush_t0_r2", {31'b0, src2_pending}, 32'h0);
      step();
      rd(0, 4, 4); #1;
      check("flush_drop_alloc", {31'b0, src1_pending}, 32'h0);
      step();
      rd(3, 1, 2); #1;
      check("flush_t3_r1", {31'b0, src1_pending}, 32'h1);
      check("flush_t3_r2", {31'b0, src2_pending}, 32'h1);
      step();

      // Exception latch, visible the following cycle on the faulting thread only.
      xcpt_valid = 1; xcpt_thread_id = 2; xcpt_pc = 32'h1000; xcpt_addr = 32'h2000;
      xcpt_type = 2'd2; rd(2, 0, 0); #1;
      check("rm0_no_bypass", rm0_pc, 32'h0);
      step(); idle(); #1;
      check("xcpt_rm0", rm0_pc, 32'h1000);
      check("xcpt_rm1", rm1_addr, 32'h2000);
      check("xcpt_rm2", rm2_type, 32'h2);
      step();
      rd(0, 0, 0); #1;
      check("t0_rm0_clean", rm0_pc, 32'h0);
      check("t0_rm2_clean", rm2_type, 32'h0);
      step();

      // r0 ignores writes and allocations.
      wb(0, 0, 0, 32'hFFFF_FFFF); alloc(0, 0, 3); step(); idle();
      rd(0, 0, 0); #1;
      check("r0_data", src1_data, 32'h0);
      check("r0_pending", {31'b0, src2_pending}, 32'h0);
      step();

      // Randomized traffic over a small register window to force collisions.
      for (int i = 0; i < 600; i++) begin
         idle();
         for (int t = 0; t < 4; t++) flush_pipeline[t] = ($urandom_range(0, 19) == 0);
         alloc_valid     = $urandom_range(0, 1);
         alloc_thread_id = 2'($urandom_range(0, 3));
         alloc_dest      = 5'($urandom_range(0, 7));
         alloc_rob_id    = 3'($urandom_range(0, 7));
         wb_writeEn      = $urandom_range(0, 1);
         wb_thread_id    = 2'($urandom_range(0, 3));
         wb_dest         = 5'($urandom_range(0, 7));
         wb_instr_id     = 3'($urandom_range(0, 7));
         wb_data         = $urandom;
         xcpt_valid      = ($urandom_range(0, 7) == 0);
         xcpt_thread_id  = 2'($urandom_range(0, 3));
         xcpt_type       = 2'($urandom_range(0, 3));
         xcpt_pc         = $urandom;
         xcpt_addr       = $urandom;
         rd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) begin
            wb_thread_id = rd_thread_id; wb_dest = src1_addr;
         end
         step();
      end

      idle();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
